// File: rtl/counter_pkg.sv
// Shared constants and state encoding for the mod-100 counter family.
package counter_pkg;
  localparam int CNT_100_MAX = 99;
  localparam int CNT_100_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;
endpackage

// File: rtl/counter_100_monitor_if.sv
// Sample input and status outputs of the mod-100 stream monitor.
interface counter_100_monitor_if #(
  parameter int CNT_W  = 7,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 16
);
  logic              i_en;
  logic [CNT_W-1:0]  i_cnt;
  logic              o_locked;
  logic              o_err;
  logic              o_range_err;
  logic              o_wrap;
  logic [ERR_W-1:0]  o_err_cnt;
  logic [WRAP_W-1:0] o_wrap_cnt;
  logic [CNT_W-1:0]  o_expected;
  logic [1:0]        o_state;

  modport master (
    output i_en, i_cnt,
    input  o_locked, o_err, o_range_err, o_wrap, o_err_cnt, o_wrap_cnt,
           o_expected, o_state
  );

  modport slave (
    input  i_en, i_cnt,
    output o_locked, o_err, o_range_err, o_wrap, o_err_cnt, o_wrap_cnt,
           o_expected, o_state
  );
endinterface

// File: rtl/counter_100_monitor_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;
endmodule

// File: rtl/counter_100_monitor.sv
// Mod-100 stream checker: locks onto the count sequence, then flags skips, repeats
// and out-of-range samples with registered pulses and saturating statistics.
module counter_100_monitor
  import counter_pkg::*;
#(
  parameter int CNT_W       = CNT_100_W,
  parameter int MAX_CNT     = CNT_100_MAX,
  parameter int LOCK_CYCLES = 2,
  parameter int ERR_W       = 8,
  parameter int WRAP_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_100_monitor_if.slave  mon
);
  state_t            r_state;
  logic [3:0]        r_run;
  logic [CNT_W-1:0]  r_expected;
  logic              r_err;
  logic              r_range_err;
  logic              r_wrap;

  logic              w_range;
  logic              w_valid;
  logic              w_match;
  logic              w_err_ev;
  logic              w_wrap_ev;
  logic              w_lock_done;
  logic [CNT_W-1:0]  w_nxt;
  logic [ERR_W-1:0]  w_err_cnt;
  logic [WRAP_W-1:0] w_wrap_cnt;

  function automatic logic [CNT_W-1:0] nxt(input logic [CNT_W-1:0] x);
    return (x == CNT_W'(MAX_CNT)) ? '0 : x + CNT_W'(1);
  endfunction

  assign w_range     = mon.i_en && (mon.i_cnt > CNT_W'(MAX_CNT));
  assign w_valid     = mon.i_en && !w_range;
  assign w_match     = (mon.i_cnt == r_expected);
  assign w_nxt       = nxt(mon.i_cnt);
  assign w_lock_done = ((r_run + 4'd1) == 4'(LOCK_CYCLES));

  // Lock is only reachable from a nonzero predecessor, so a matched 0 is always a wrap.
  assign w_err_ev  = (r_state == ST_LOCKED) && (w_range || (w_valid && !w_match));
  assign w_wrap_ev = (r_state == ST_LOCKED) && w_valid && w_match && (mon.i_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_run       <= '0;
      r_expected  <= '0;
      r_err       <= 1'b0;
      r_range_err <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_err       <= w_err_ev;
      r_range_err <= w_range;
      r_wrap      <= w_wrap_ev;
      if (w_range) begin
        r_state <= ST_IDLE;
        r_run   <= '0;
      end else if (w_valid) begin
        r_expected <= w_nxt;
        case (r_state)
          ST_IDLE: begin
            r_run   <= '0;
            r_state <= ST_SYNC;
          end
          ST_SYNC: begin
            if (w_match && w_lock_done) begin
              r_run   <= '0;
              r_state <= ST_LOCKED;
            end else if (w_match) begin
              r_run <= r_run + 4'd1;
            end else begin
              r_run <= '0;
            end
          end
          ST_LOCKED: begin
            if (!w_match) begin
              r_run   <= '0;
              r_state <= ST_SYNC;
            end
          end
          default: begin
            r_run   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_err_ev),
    .count (w_err_cnt)
  );

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wrap_ev),
    .count (w_wrap_cnt)
  );

  assign mon.o_locked    = (r_state == ST_LOCKED);
  assign mon.o_err       = r_err;
  assign mon.o_range_err = r_range_err;
  assign mon.o_wrap      = r_wrap;
  assign mon.o_err_cnt   = w_err_cnt;
  assign mon.o_wrap_cnt  = w_wrap_cnt;
  assign mon.o_expected  = r_expected;
  assign mon.o_state     = r_state;
endmodule

// File: tb/tb_counter_100_monitor.sv
// Bench for counter_100_monitor: vector table, directed corner sequences, random stream vs reference model.
module tb_counter_100_monitor;
  logic clk;
  logic reset;

  counter_100_monitor_if #(.CNT_W(7), .ERR_W(8), .WRAP_W(16)) bus ();

  counter_100_monitor dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: state 0/1/2, next expected value, consecutive-match run.
  int m_state, m_exp, m_run, m_ecnt, m_wcnt;
  int m_err, m_rng, m_wrap;

  function automatic void model_reset();
    m_state = 0; m_exp = 0; m_run = 0; m_ecnt = 0; m_wcnt = 0;
    m_err = 0; m_rng = 0; m_wrap = 0;
  endfunction

  function automatic void model_step(input int en, input int cnt);
    m_err = 0; m_rng = 0; m_wrap = 0;
    if (en == 0) return;
    if (cnt > 99) begin
      m_rng = 1;
      if (m_state == 2) m_err = 1;
      m_state = 0;
      m_run = 0;
    end else begin
      if (m_state == 0) begin
        m_state = 1;
        m_run = 0;
      end else if (m_state == 1) begin
        if (cnt == m_exp) begin
          m_run = m_run + 1;
          if (m_run == 2) begin m_state = 2; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else begin
        if (cnt == m_exp) begin
          if (cnt == 0) m_wrap = 1;
        end else begin
          m_err = 1;
          m_state = 1;
          m_run = 0;
        end
      end
      m_exp = (cnt + 1) % 100;
    end
    if (m_err == 1 && m_ecnt < 255) m_ecnt = m_ecnt + 1;
    if (m_wrap == 1 && m_wcnt < 65535) m_wcnt = m_wcnt + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},    int'(bus.o_state),     m_state);
    chk({tag, ".locked"},   int'(bus.o_locked),    (m_state == 2) ? 1 : 0);
    chk({tag, ".err"},      int'(bus.o_err),       m_err);
    chk({tag, ".range"},    int'(bus.o_range_err), m_rng);
    chk({tag, ".wrap"},     int'(bus.o_wrap),      m_wrap);
    chk({tag, ".err_cnt"},  int'(bus.o_err_cnt),   m_ecnt);
    chk({tag, ".wrap_cnt"}, int'(bus.o_wrap_cnt),  m_wcnt);
    chk({tag, ".expected"}, int'(bus.o_expected),  m_exp);
  endtask

  task automatic step(input string tag, input int en, input int cnt);
    @(negedge clk);
    bus.i_en  = en[0];
    bus.i_cnt = cnt[6:0];
    @(posedge clk);
    #1;
    model_step(en, cnt);
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".state"},    int'(bus.o_state),     0);
    chk({tag, ".locked"},   int'(bus.o_locked),    0);
    chk({tag, ".err"},      int'(bus.o_err),       0);
    chk({tag, ".range"},    int'(bus.o_range_err), 0);
    chk({tag, ".wrap"},     int'(bus.o_wrap),      0);
    chk({tag, ".err_cnt"},  int'(bus.o_err_cnt),   0);
    chk({tag, ".wrap_cnt"}, int'(bus.o_wrap_cnt),  0);
    chk({tag, ".expected"}, int'(bus.o_expected),  0);
  endtask

  // Reset asserted between clock edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int en; int cnt; int st; int err; int rng; int wrap; int expv; int ecnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1,   0, 1, 0, 0, 0, 1, 0};
    tbl[1]  = '{1,   1, 1, 0, 0, 0, 2, 0};
    tbl[2]  = '{1,   2, 2, 0, 0, 0, 3, 0};
    tbl[3]  = '{1,   3, 2, 0, 0, 0, 4, 0};
    tbl[4]  = '{1,   5, 1, 1, 0, 0, 6, 1};
    tbl[5]  = '{1,   6, 1, 0, 0, 0, 7, 1};
    tbl[6]  = '{1,   7, 2, 0, 0, 0, 8, 1};
    tbl[7]  = '{0,  42, 2, 0, 0, 0, 8, 1};
    tbl[8]  = '{1, 120, 0, 1, 1, 0, 8, 2};
    tbl[9]  = '{1,  99, 1, 0, 0, 0, 0, 2};
    tbl[10] = '{1,   0, 1, 0, 0, 0, 1, 2};
    tbl[11] = '{1,   1, 2, 0, 0, 0, 2, 2};
    tbl[12] = '{1,   1, 1, 1, 0, 0, 2, 3};
    tbl[13] = '{1,   2, 1, 0, 0, 0, 3, 3};
    tbl[14] = '{1,   3, 2, 0, 0, 0, 4, 3};

    reset     = 1'b0;
    bus.i_en  = 1'b0;
    bus.i_cnt = '0;
    model_reset();
    #100 reset = 1'b1;
    #10  reset = 1'b0;
    #1;
    check_zero("reset");

    for (int i = 0; i < 15; i++) begin
      step("tbl", tbl[i].en, tbl[i].cnt);
      chk($sformatf("tbl%0d.state", i),    int'(bus.o_state),     tbl[i].st);
      chk($sformatf("tbl%0d.err", i),      int'(bus.o_err),       tbl[i].err);
      chk($sformatf("tbl%0d.range", i),    int'(bus.o_range_err), tbl[i].rng);
      chk($sformatf("tbl%0d.wrap", i),     int'(bus.o_wrap),      tbl[i].wrap);
      chk($sformatf("tbl%0d.expected", i), int'(bus.o_expected),  tbl[i].expv);
      chk($sformatf("tbl%0d.err_cnt", i),  int'(bus.o_err_cnt),   tbl[i].ecnt);
    end

    // Clean stream through two 99->0 wraps.
    async_reset("rst_wrap");
    for (int i = 0; i <= 200; i++) begin
      step("stream", 1, i % 100);
      if (i == 2) chk("stream.lock_at_2", int'(bus.o_state), 2);
      if (i == 100 || i == 200) chk("stream.wrap_pulse", int'(bus.o_wrap), 1);
    end
    chk("stream.wrap_cnt", int'(bus.o_wrap_cnt), 2);
    chk("stream.err_cnt",  int'(bus.o_err_cnt),  0);

    // Skip detection, relock, enable gap, range error while locked.
    async_reset("rst_skip");
    step("skip", 1, 7);
    step("skip", 1, 8);
    step("skip", 1, 9);
    step("skip", 1, 10);
    step("skip", 1, 11);
    step("skip", 1, 13);
    chk("skip.err_pulse", int'(bus.o_err),      1);
    chk("skip.err_cnt",   int'(bus.o_err_cnt),  1);
    chk("skip.state",     int'(bus.o_state),    1);
    chk("skip.expected",  int'(bus.o_expected), 14);
    step("relock", 1, 14);
    step("relock", 1, 15);
    chk("relock.state", int'(bus.o_state), 2);
    for (int v = 16; v <= 42; v++) step("run", 1, v);
    for (int k = 0; k < 5; k++) begin
      step("en_low", 0, 42);
      chk("en_low.pulses", int'({bus.o_err, bus.o_range_err, bus.o_wrap}), 0);
      chk("en_low.state", int'(bus.o_state), 2);
      chk("en_low.expected", int'(bus.o_expected), 43);
    end
    step("resume", 1, 43);
    chk("resume.err", int'(bus.o_err), 0);
    step("range", 1, 120);
    chk("range.rng",     int'(bus.o_range_err), 1);
    chk("range.err",     int'(bus.o_err),       1);
    chk("range.state",   int'(bus.o_state),     0);
    chk("range.err_cnt", int'(bus.o_err_cnt),   2);

    // Error counter saturation: 300 lock-then-mismatch cycles.
    async_reset("rst_sat");
    step("sat", 1, 10);
    for (int k = 0; k < 300; k++) begin
      step("sat", 1, 11);
      step("sat", 1, 12);
      step("sat", 1, 10);
    end
    chk("sat.err_cnt",   int'(bus.o_err_cnt), 255);
    chk("sat.err_pulse", int'(bus.o_err),     1);
    async_reset("rst_mid");

    // Random stream, mostly in sequence, with gaps, skips and out-of-range values.
    for (int k = 0; k < 3000; k++) begin
      int r, en, cnt;
      r   = $urandom_range(0, 99);
      en  = ($urandom_range(0, 9) < 8) ? 1 : 0;
      if (r < 75)      cnt = m_exp;
      else if (r < 85) cnt = m_exp;
      else if (r < 95) cnt = $urandom_range(0, 99);
      else             cnt = $urandom_range(100, 127);
      if (r >= 75 && r < 85 && m_exp != 0) cnt = m_exp - 1;
      step("rand", en, cnt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/counter_100_monitor.md
Name: counter_100_monitor

Overview:
- Receive-side checker for a mod-100 counter stream (0..99, wrap 99->0), the consumer end of the counter_100 count interface.
- Samples the count on each enabled cycle, locks onto the sequence, then flags every skipped, repeated or out-of-range value.
- Keeps saturating error and wrap statistics.
- Sits beside any counter_100 instance, in benches or on-chip as a health monitor on o_cnt or o_cnt_always.

Parameters:
- CNT_W, 7, width of the monitored count.
- MAX_CNT, 99, terminal count; the next value after MAX_CNT is 0.
- LOCK_CYCLES, 2, consecutive correct increments required to enter LOCKED (1..15).
- ERR_W, 8, width of the saturating error counter.
- WRAP_W, 16, width of the saturating wrap counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_en  in  1  sample strobe; i_cnt is evaluated only when high.
- i_cnt  in  CNT_W  monitored count value.
- o_locked  out  1  high while in LOCKED.
- o_err  out  1  one-cycle pulse per mismatch detected in LOCKED.
- o_range_err  out  1  one-cycle pulse per sample with i_cnt > MAX_CNT, in any state.
- o_wrap  out  1  one-cycle pulse when a matched 99->0 transition is seen in LOCKED.
- o_err_cnt  out  ERR_W  saturating count of o_err pulses.
- o_wrap_cnt  out  WRAP_W  saturating count of o_wrap pulses.
- o_expected  out  CNT_W  next value the monitor expects.
- o_state  out  2  FSM state: IDLE=0, SYNC=1, LOCKED=2.

Behaviour:
- Reset:
  - Asynchronous assert clears everything immediately: state IDLE, all pulses 0, counters 0, o_expected 0, run counter 0.
  - Reset asserted mid-operation discards lock and statistics.
- Outputs and latency:
  - All outputs are registered.
  - A sample taken at edge N affects outputs right after edge N (1-cycle latency from input presentation).
- Enable and range:
  - With i_en=0, state, expected value and counters hold, and all pulses are 0.
  - nxt(x) = (x == MAX_CNT) ? 0 : x+1, computed CNT_W wide; no arithmetic overflow path.
  - Range error, any state: i_en=1 and i_cnt > MAX_CNT -> pulse o_range_err.
    - Go to IDLE, run=0, o_expected unchanged.
    - In LOCKED, also pulse o_err and increment o_err_cnt.
- IDLE:
  - A valid sample (i_en=1, in range) sets expected=nxt(i_cnt), run=0 -> SYNC.
- SYNC:
  - On a valid sample equal to expected: expected=nxt(i_cnt), run=run+1.
    - When run+1 == LOCK_CYCLES, go to LOCKED and clear run.
  - On a valid sample not equal to expected: expected=nxt(i_cnt), run=0, stay in SYNC, no o_err.
- LOCKED:
  - On a valid match: expected=nxt(i_cnt).
    - If i_cnt == 0, pulse o_wrap and increment o_wrap_cnt. Lock can only be reached with a nonzero predecessor, so 0 is always a 99->0 wrap.
  - On a valid mismatch: pulse o_err, increment o_err_cnt, expected=nxt(i_cnt), run=0 -> SYNC, o_locked falls on the same edge.
- Saturation:
  - o_err_cnt and o_wrap_cnt stop at all-ones and never wrap.
  - Pulses still fire at saturation.
- Simultaneous events:
  - A wrap and an error cannot coincide.
  - A range error takes priority over the match check.
- Held value: a repeated value in LOCKED (counter stalled while i_en=1) is a mismatch.

Decomposition:
- Shared package counter_pkg holds:
  - the state encoding constants ST_IDLE, ST_SYNC, ST_LOCKED;
  - CNT_100_MAX = 99;
  - CNT_100_W = 7.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice for the error and wrap counters.
- nxt() and the FSM stay in the top module.

Test Plan:
- Reset at t=100ns for 10ns, then a clean stream 0,1,2,... with i_en=1: o_state goes 0->1 on sample 0, then to 2 on sample 2. o_locked=1, o_err_cnt=0.
- Clean stream run through 98,99,0: exactly one o_wrap pulse on the cycle after sample 0, o_wrap_cnt=1. After 2000ns of clean counting (~2 wraps), o_wrap_cnt=2 and o_err_cnt=0.
- While locked, inject 10,11,13: one o_err pulse after sample 13, o_err_cnt=1, state SYNC, o_expected=14. Samples 14,15 relock (o_state=2).
- Inject 120 while locked: o_range_err=1 and o_err=1 on the same cycle, state IDLE, o_err_cnt increments.
- Toggle i_en low for 5 cycles with i_cnt frozen at 42 while locked: no pulses, state LOCKED, o_expected=43. Resume at 43: no error.
- Force 300 mismatches: o_err_cnt saturates at 255 and o_err still pulses. Assert reset mid-stream: all outputs 0 immediately without waiting for a clock edge.
